// File: rtl/rv32_pkg.sv
// Shared RV32 data-memory definitions: responder FSM encoding and the read data
// returned for an aborted external access.
package rv32_pkg;

    localparam int unsigned RV32_XLEN = 32;

    localparam logic [RV32_XLEN-1:0] RV32_DMEM_FAULT_DATA = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LRD,
        ST_EXT_WR,
        ST_EXT_RD,
        ST_EXT_RWAIT,
        ST_RDONE
    } dmem_state_e;

    // States in which an external bus transaction is outstanding.
    function automatic logic dmem_is_ext(input dmem_state_e s);
        return (s == ST_EXT_WR) || (s == ST_EXT_RD) || (s == ST_EXT_RWAIT);
    endfunction

endpackage

// File: rtl/rv32_dmem_ram.sv
// Byte-enabled single-port word RAM with a registered read port.
module rv32_dmem_ram
    import rv32_pkg::*;
#(
    parameter int unsigned WORD_BITS = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [WORD_BITS-1:0] addr,
    input  logic [RV32_XLEN-1:0] wdata,
    output logic [RV32_XLEN-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << WORD_BITS;

    logic [RV32_XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (en) rdata <= mem[addr];
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Load/store target for the RV32 ALU stage: local block RAM plus an optional
// external wait-state bus enabled by RV32_DMEM_EXT_BUS_EN.
module rv32_dmem_responder
    import rv32_pkg::*;
#(
    parameter int unsigned LOCAL_ADDR_BITS = 12,
    parameter logic [31:0] LOCAL_BASE      = 32'h0000_0000,
    parameter int unsigned EXT_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [3:0]  st_be,
    input  logic [31:0] wr_data,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        access_fault,
    output logic [31:0] ext_addr,
    output logic        ext_read,
    output logic        ext_write,
    output logic [3:0]  ext_be,
    output logic [31:0] ext_wdata,
    input  logic        ext_waitrequest,
    input  logic [31:0] ext_rdata,
    input  logic        ext_rdatavalid
);

    localparam int unsigned WORD_BITS = LOCAL_ADDR_BITS - 2;

    dmem_state_e state, state_nxt;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic        local_hit;

`ifdef RV32_DMEM_EXT_BUS_EN
    localparam int unsigned TMO_BITS = $clog2(EXT_TIMEOUT + 1);

    logic [TMO_BITS-1:0] tmo_q, tmo_d;
    logic                tmo_hit;
    logic                ext_read_d, ext_write_d, fault_d;
    logic [31:0]         ext_addr_d, ext_wdata_d, rd_q, rd_d;
    logic [3:0]          ext_be_d;
    logic                unused_addr_lsb;

    assign local_hit       = (addr[31:LOCAL_ADDR_BITS] == LOCAL_BASE[31:LOCAL_ADDR_BITS]);
    assign tmo_hit         = (tmo_q == TMO_BITS'(EXT_TIMEOUT));
    assign unused_addr_lsb = ^addr[1:0];
`else
    logic unused_ext;

    // Every address maps into the RAM, wrapping on its size.
    assign local_hit  = 1'b1;
    assign unused_ext = ^{addr[31:LOCAL_ADDR_BITS], addr[1:0], ext_waitrequest,
                          ext_rdata, ext_rdatavalid, LOCAL_BASE, 1'(EXT_TIMEOUT)};
`endif

    rv32_dmem_ram #(.WORD_BITS(WORD_BITS)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr[LOCAL_ADDR_BITS-1:2]),
        .wdata (wr_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state, RAM strobes and next values of the registered bus outputs.
    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 4'h0;
`ifdef RV32_DMEM_EXT_BUS_EN
        ext_read_d  = ext_read;
        ext_write_d = ext_write;
        ext_addr_d  = ext_addr;
        ext_be_d    = ext_be;
        ext_wdata_d = ext_wdata;
        rd_d        = rd_q;
        fault_d     = 1'b0;
        tmo_d       = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (store && local_hit) begin
                    ram_we = st_be;
                end else if (load && !store && local_hit) begin
                    ram_en    = 1'b1;
                    state_nxt = ST_LRD;
                end
`ifdef RV32_DMEM_EXT_BUS_EN
                else if (store) begin
                    state_nxt   = ST_EXT_WR;
                    ext_write_d = 1'b1;
                    ext_addr_d  = {addr[31:2], 2'b00};
                    ext_be_d    = st_be;
                    ext_wdata_d = wr_data;
                end else if (load) begin
                    state_nxt  = ST_EXT_RD;
                    ext_read_d = 1'b1;
                    ext_addr_d = {addr[31:2], 2'b00};
                    ext_be_d   = 4'hF;
                end
`endif
            end
            ST_LRD, ST_RDONE: state_nxt = ST_IDLE;
`ifdef RV32_DMEM_EXT_BUS_EN
            ST_EXT_WR: begin
                if (!ext_waitrequest || tmo_hit) begin
                    state_nxt   = ST_IDLE;
                    ext_write_d = 1'b0;
                    fault_d     = ext_waitrequest;
                end
            end
            ST_EXT_RD: begin
                if (!ext_waitrequest) begin
                    ext_read_d = 1'b0;
                    if (ext_rdatavalid) begin
                        rd_d      = ext_rdata;
                        state_nxt = ST_RDONE;
                    end else begin
                        state_nxt = ST_EXT_RWAIT;
                    end
                end else if (tmo_hit) begin
                    ext_read_d = 1'b0;
                    rd_d       = RV32_DMEM_FAULT_DATA;
                    fault_d    = 1'b1;
                    state_nxt  = ST_RDONE;
                end
            end
            ST_EXT_RWAIT: begin
                if (ext_rdatavalid) begin
                    rd_d      = ext_rdata;
                    state_nxt = ST_RDONE;
                end else if (tmo_hit) begin
                    rd_d      = RV32_DMEM_FAULT_DATA;
                    fault_d   = 1'b1;
                    state_nxt = ST_RDONE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
`ifdef RV32_DMEM_EXT_BUS_EN
        // Counter restarts on every state change and only runs while an EXT state is held.
        if (state_nxt == state && dmem_is_ext(state)) tmo_d = tmo_q + TMO_BITS'(1);
`endif
    end

`ifdef RV32_DMEM_EXT_BUS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_read     <= 1'b0;
            ext_write    <= 1'b0;
            ext_addr     <= '0;
            ext_be       <= '0;
            ext_wdata    <= '0;
            access_fault <= 1'b0;
            rd_q         <= '0;
            tmo_q        <= '0;
        end else begin
            ext_read     <= ext_read_d;
            ext_write    <= ext_write_d;
            ext_addr     <= ext_addr_d;
            ext_be       <= ext_be_d;
            ext_wdata    <= ext_wdata_d;
            access_fault <= fault_d;
            rd_q         <= rd_d;
            tmo_q        <= tmo_d;
        end
    end

    assign ld_data = (state == ST_RDONE) ? rd_q :
                     (state == ST_LRD)   ? ram_rdata : '0;
`else
    assign ext_read     = 1'b0;
    assign ext_write    = 1'b0;
    assign ext_addr     = '0;
    assign ext_be       = '0;
    assign ext_wdata    = '0;
    assign access_fault = 1'b0;
    assign ld_data      = (state == ST_LRD) ? ram_rdata : '0;
`endif

    // Freeze is released while reset is asserted so a mid-access reset frees the pipeline at once.
    assign stall = reset_n & ((state == ST_IDLE && load) || dmem_is_ext(state));

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Self-checking bench for rv32_dmem_responder: directed vector table, hand-written
// multi-cycle sequences and a random local load/store mix against a word-array model.
module tb_rv32_dmem_responder;

    localparam int unsigned TMO = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  st_be = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] ld_data;
    logic        stall;
    logic        access_fault;
    logic [31:0] ext_addr;
    logic        ext_read;
    logic        ext_write;
    logic [3:0]  ext_be;
    logic [31:0] ext_wdata;
    logic        ext_waitrequest = 1'b0;
    logic [31:0] ext_rdata = '0;
    logic        ext_rdatavalid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_model [1024];

    typedef struct {
        bit          is_store;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    rv32_dmem_responder dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .load            (load),
        .store           (store),
        .addr            (addr),
        .st_be           (st_be),
        .wr_data         (wr_data),
        .ld_data         (ld_data),
        .stall           (stall),
        .access_fault    (access_fault),
        .ext_addr        (ext_addr),
        .ext_read        (ext_read),
        .ext_write       (ext_write),
        .ext_be          (ext_be),
        .ext_wdata       (ext_wdata),
        .ext_waitrequest (ext_waitrequest),
        .ext_rdata       (ext_rdata),
        .ext_rdatavalid  (ext_rdatavalid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        tick();
        store = 1'b1; load = 1'b0; addr = a; st_be = be; wr_data = d;
        settle();
        chk("store_no_stall", 32'(stall), 32'd0);
        mem_model[widx(a)] = merge(mem_model[widx(a)], be, d);
    endtask

    task automatic do_load(input string name, input logic [31:0] a, input logic [31:0] exp);
        tick();
        load = 1'b1; store = 1'b0; addr = a;
        settle();
        chk({name, "_req_stall"}, 32'(stall), 32'd1);
        tick();
        settle();
        chk({name, "_data_stall"}, 32'(stall), 32'd0);
        chk({name, "_data"}, ld_data, exp);
    endtask

    task automatic go_idle();
        tick();
        load = 1'b0; store = 1'b0;
        settle();
    endtask

    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        tick();
        reset_n = 1'b1; load = 1'b0; store = 1'b0;
        ext_waitrequest = 1'b0; ext_rdatavalid = 1'b0;
    endtask

    task automatic seq_load_store_collide();
        tick();
        load = 1'b1; store = 1'b1; addr = 32'h20; st_be = 4'hF; wr_data = 32'h55AA_33CC;
        settle();
        chk("collide_stall_c0", 32'(stall), 32'd1);
        mem_model[widx(32'h20)] = 32'h55AA_33CC;
        tick();
        store = 1'b0;
        settle();
        chk("collide_stall_c1", 32'(stall), 32'd1);
        tick();
        settle();
        chk("collide_stall_c2", 32'(stall), 32'd0);
        chk("collide_data", ld_data, 32'h55AA_33CC);
    endtask

    task automatic seq_reset_local_load();
        tick();
        load = 1'b1; store = 1'b0; addr = 32'h14;
        settle();
        chk("rst_lrd_stall_before", 32'(stall), 32'd1);
        pulse_reset();
        chk("rst_lrd_stall_after", 32'(stall), 32'd0);
        chk("rst_lrd_ld_data", ld_data, 32'd0);
        release_reset();
        do_load("post_rst_local", 32'h14, mem_model[widx(32'h14)]);
    endtask

    task automatic seq_random(input int n_ops);
        logic [31:0] r, a;
        int unsigned idx, op;
        for (int w = 0; w < 16; w++) do_store(32'(w) << 2, 4'hF, $urandom());
        for (int i = 0; i < n_ops; i++) begin
            r   = $urandom();
            idx = $urandom_range(0, 15);
            op  = $urandom_range(0, 2);
`ifdef RV32_DMEM_EXT_BUS_EN
            a = {20'h0, 10'(idx), r[1:0]};
`else
            a = {r[31:12], 10'(idx), r[1:0]};
            ext_waitrequest = r[5];
            ext_rdatavalid  = r[6];
            ext_rdata       = $urandom();
`endif
            if (op == 0) do_store(a, 4'($urandom_range(0, 15)), $urandom());
            else if (op == 1) do_load("rnd_load", a, mem_model[widx(a)]);
            else begin
                go_idle();
                chk("rnd_idle_stall", 32'(stall), 32'd0);
            end
`ifndef RV32_DMEM_EXT_BUS_EN
            chk("rnd_ext_ctrl_zero", 32'({ext_read, ext_write, access_fault, ext_be}), 32'd0);
            chk("rnd_ext_data_zero", ext_addr | ext_wdata, 32'd0);
`endif
        end
        go_idle();
    endtask

`ifdef RV32_DMEM_EXT_BUS_EN
    task automatic seq_ext_read();
        int stall_n, rd_n;
        bit done;
        logic [31:0] got;
        stall_n = 0; rd_n = 0; done = 1'b0; got = '0;
        for (int c = 0; c < 50 && !done; c++) begin
            tick();
            if (c == 0) begin load = 1'b1; store = 1'b0; addr = 32'h8000_0000; end
            ext_waitrequest = (c >= 1 && c <= 3);
            ext_rdatavalid  = (c == 5);
            ext_rdata       = (c == 5) ? 32'hCAFE_F00D : 32'h0;
            settle();
            if (ext_read) begin
                rd_n++;
                if (rd_n == 1) begin
                    chk("ext_rd_addr", ext_addr, 32'h8000_0000);
                    chk("ext_rd_be", 32'(ext_be), 32'hF);
                end
            end
            if (stall) stall_n++;
            else begin done = 1'b1; got = ld_data; end
        end
        chk("ext_rd_done", 32'(done), 32'd1);
        chk("ext_rd_stall_cycles", 32'(stall_n), 32'd6);
        chk("ext_rd_read_cycles", 32'(rd_n), 32'd4);
        chk("ext_rd_data", got, 32'hCAFE_F00D);
        ext_rdatavalid = 1'b0;
        go_idle();
    endtask

    task automatic seq_ext_write();
        int stall_n, wr_n;
        stall_n = 0; wr_n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            store = (c == 0); load = 1'b0;
            if (c == 0) begin addr = 32'h8000_0006; st_be = 4'b0101; wr_data = 32'hDEAD_BEEF; end
            ext_waitrequest = (c == 1 || c == 2);
            settle();
            if (ext_write) begin
                wr_n++;
                if (wr_n == 1) begin
                    chk("ext_wr_addr", ext_addr, 32'h8000_0004);
                    chk("ext_wr_be", 32'(ext_be), 32'h5);
                    chk("ext_wr_wdata", ext_wdata, 32'hDEAD_BEEF);
                end
            end
            if (stall) stall_n++;
        end
        chk("ext_wr_write_cycles", 32'(wr_n), 32'd3);
        chk("ext_wr_stall_cycles", 32'(stall_n), 32'd3);
    endtask

    task automatic seq_timeout();
        int stall_n, fault_n;
        bit done;
        logic [31:0] got;
        logic fault_stall;
        stall_n = 0; fault_n = 0; done = 1'b0; got = 32'hFFFF_FFFF; fault_stall = 1'b1;
        for (int c = 0; c < int'(TMO) + 20; c++) begin
            tick();
            load = (c == 0) || !done; store = 1'b0;
            if (c == 0) addr = 32'h9000_0000;
            ext_waitrequest = 1'b1;
            settle();
            if (access_fault) begin fault_n++; fault_stall = stall; end
            if (stall) stall_n++;
            else if (!done) begin done = 1'b1; got = ld_data; end
        end
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_fault_pulses", 32'(fault_n), 32'd1);
        chk("tmo_fault_stall", 32'(fault_stall), 32'd0);
        chk("tmo_ld_data", got, 32'd0);
        chk("tmo_stall_in_range", 32'(stall_n >= int'(TMO) + 1 && stall_n <= int'(TMO) + 2), 32'd1);
        chk("tmo_read_dropped", 32'(ext_read), 32'd0);
        ext_waitrequest = 1'b0;
        go_idle();
    endtask

    task automatic seq_reset_ext();
        for (int c = 0; c < 3; c++) begin
            tick();
            load = 1'b1; store = 1'b0; addr = 32'h8000_0010;
            ext_waitrequest = 1'b0; ext_rdatavalid = 1'b0;
            settle();
        end
        chk("rst_rwait_stall_before", 32'(stall), 32'd1);
        pulse_reset();
        chk("rst_rwait_stall_after", 32'(stall), 32'd0);
        chk("rst_rwait_read_after", 32'(ext_read), 32'd0);
        release_reset();
        tick();
        store = 1'b1; load = 1'b0; addr = 32'h8000_0020; st_be = 4'hF; wr_data = 32'h1;
        ext_waitrequest = 1'b1;
        tick();
        store = 1'b0;
        settle();
        chk("rst_wr_write_before", 32'(ext_write), 32'd1);
        pulse_reset();
        chk("rst_wr_write_after", 32'(ext_write), 32'd0);
        release_reset();
        for (int c = 0; c < 3; c++) tick();
        chk("rst_wr_discarded", 32'(ext_write), 32'd0);
        do_load("post_rst_ext", 32'h20, mem_model[widx(32'h20)]);
        go_idle();
    endtask
`endif

    initial begin
        vecs[0] = '{1'b1, 32'h10, 4'hF,    32'h1234_5678, 32'h0};
        vecs[1] = '{1'b0, 32'h10, 4'h0,    32'h0,         32'h1234_5678};
        vecs[2] = '{1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 32'h0};
        vecs[3] = '{1'b0, 32'h10, 4'h0,    32'h0,         32'h1234_AB78};
        vecs[4] = '{1'b1, 32'h14, 4'hF,    32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1'b1, 32'h17, 4'b1001, 32'hA100_00B2, 32'h0};
        vecs[6] = '{1'b0, 32'h14, 4'h0,    32'h0,         32'hA1FF_FFB2};
        vecs[7] = '{1'b0, 32'h10, 4'h0,    32'h0,         32'h1234_AB78};
        vecs[8] = '{1'b1, 32'h10, 4'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[9] = '{1'b0, 32'h12, 4'h0,    32'h0,         32'h1234_AB78};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_ld_data", ld_data, 32'd0);
        chk("reset_ext_ctrl", 32'({ext_read, ext_write, access_fault, ext_be}), 32'd0);
        chk("reset_ext_data", ext_addr | ext_wdata, 32'd0);
        release_reset();
        settle();
        chk("post_reset_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_store) do_store(vecs[i].a, vecs[i].be, vecs[i].d);
            else do_load($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
        end
        go_idle();

`ifndef RV32_DMEM_EXT_BUS_EN
        do_load("wrap_load", 32'h0000_1010, 32'h1234_AB78);
        do_store(32'hFFFF_F020, 4'hF, 32'h0BAD_CAFE);
        do_load("wrap_store", 32'h20, 32'h0BAD_CAFE);
        go_idle();
`endif

        seq_load_store_collide();
        go_idle();
        seq_reset_local_load();
        go_idle();
        seq_random(300);

`ifdef RV32_DMEM_EXT_BUS_EN
        seq_ext_read();
        seq_ext_write();
        seq_timeout();
        seq_reset_ext();
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_dmem_responder.md
# rv32_dmem_responder

Data-memory responder for the RV32 soft core: the target end of the ALU stage's load/store interface. It services word-aligned loads and byte-enabled stores from a local block RAM, or forwards them to an external memory-mapped bus with wait states. It returns `ld_data` and drives `stall` back into the pipeline until read data is valid or a posted external write has drained.

## Interface
Parameters:
- `LOCAL_ADDR_BITS`, default 12: byte-address width of the local RAM, giving 2^(n-2) words.
- `LOCAL_BASE`, default 32'h0000_0000: base of the local region; only bits [31:LOCAL_ADDR_BITS] are compared.
- `EXT_TIMEOUT`, default 255: maximum cycles an external access may wait before it is aborted.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: load request; held high by upstream while `stall` is high.
- `store` in 1: single-cycle store strobe.
- `addr` in 32: word-aligned access address; bits [1:0] are ignored.
- `st_be` in 4: store byte enables.
- `wr_data` in 32: store data, already lane-shifted.
- `ld_data` out 32: load data; valid in the cycle `load` is high and `stall` is low.
- `stall` out 1: pipeline freeze (combinational).
- `access_fault` out 1: one-cycle pulse on external timeout.
- `ext_addr` out 32: external bus address.
- `ext_read` out 1: external read request.
- `ext_write` out 1: external write request.
- `ext_be` out 4: external byte enables.
- `ext_wdata` out 32: external write data.
- `ext_waitrequest` in 1: external bus holds the current command while high.
- `ext_rdata` in 32: external read data.
- `ext_rdatavalid` in 1: qualifies `ext_rdata`.

## Operation
- **Local hit:** `addr[31:LOCAL_ADDR_BITS] == LOCAL_BASE[31:LOCAL_ADDR_BITS]`. Anything else is external.
- **FSM states:** IDLE, LRD, EXT_WR, EXT_RD, EXT_RWAIT, RDONE.
- **IDLE, local store:** bytes are written per `st_be` on the same edge. No stall, and the FSM stays in IDLE.
- **IDLE, local load:** the RAM read is registered and the FSM goes to LRD. `stall` is high in the request cycle.
- **LRD:** `ld_data` = RAM output and `stall` = 0. Next state is IDLE. The still-high `load` in this cycle is not treated as a new request.
- **IDLE, external store:** `addr`/`st_be`/`wr_data` are captured into a posted-write register and the FSM goes to EXT_WR. `ext_write` is held until a cycle with `ext_waitrequest` = 0, then the FSM returns to IDLE.
- **IDLE, external load:** the FSM goes to EXT_RD, with `ext_read` and `ext_be` = 4'hF held until `ext_waitrequest` = 0. It then goes to EXT_RWAIT, or straight to RDONE if `ext_rdatavalid` is already high in that cycle. EXT_RWAIT waits for `ext_rdatavalid`; the data is captured on that edge.
- **RDONE:** `ld_data` = captured data and `stall` = 0. Next state is IDLE.
- **Stall:** `stall` = (state ∈ {EXT_WR, EXT_RD, EXT_RWAIT}) | (state == IDLE & `load`).
- **Upstream rule:** upstream must not issue `store` while `stall` is high.
- **Simultaneous `load` & `store` in IDLE:** the store is serviced first and the load stays stalled.
- **Timeout:** a counter clears on entry to any EXT state and increments each cycle in it. When it reaches `EXT_TIMEOUT`:
  - `ext_read`/`ext_write` drop and `access_fault` pulses.
  - A read goes to RDONE with data 32'h0.
  - A write goes to IDLE.
- **Reset values:** state IDLE, `ext_read`/`ext_write`/`access_fault` 0, `ext_addr`/`ext_wdata` 0, `ext_be` 0, timeout counter 0, `ld_data` 0.
- **Reset mid-access:** bus requests drop asynchronously and the posted write is discarded. RAM contents are not reset.

## Timing
- **Local load:** 1 stall cycle; data in cycle N+1.
- **Local store:** 0 stall cycles.
- **External read:** at least 2 stall cycles (EXT_RD plus the `ext_rdatavalid` cycle), then data in RDONE.
- **External write:** stalls for 1 + (number of `ext_waitrequest` high cycles).
- **Bus outputs:** `ext_*` outputs are registered and change only on state entry or exit.

## Configuration
- **`RV32_DMEM_EXT_BUS_EN` defined:** external path as described above.
- **Undefined:**
  - All addresses hit local RAM, wrapping modulo the RAM size.
  - EXT states, the timeout counter and the posted write are removed.
  - `ext_*` outputs are tied to 0 and `access_fault` is tied to 0.
  - `ext_*` inputs are ignored.

## Structure
- **Shared `rv32_pkg`:** FSM state encoding and the `RV32_DMEM_FAULT_DATA` constant (32'h0).
- **Sub-module `rv32_dmem_ram`:** byte-enabled single-port RAM, depth from `LOCAL_ADDR_BITS`, registered read.

## Test plan
- **Local write then read:** store 32'h1234_5678 to 0x10 with `st_be` 4'hF, then load 0x10. Expect `stall` high 1 cycle, then `ld_data` = 32'h1234_5678.
- **Byte write:** store 32'h0000_AB00 to 0x10 with `st_be` 4'b0010, then load 0x10. Expect 32'h1234_AB78.
- **External read with waits:** load 0x8000_0000, `ext_waitrequest` high 3 cycles, `ext_rdatavalid` 2 cycles later with 32'hCAFE_F00D. Expect `stall` high for 6 cycles, then `ld_data` = 32'hCAFE_F00D for 1 cycle.
- **External write with waits:** store to 0x8000_0004, `ext_waitrequest` high 2 cycles. Expect `ext_write` high 3 cycles, `stall` high 3 cycles, `ext_be`/`ext_wdata` matching the inputs.
- **Timeout:** external load with `ext_waitrequest` stuck high. After 255 cycles expect a single `access_fault` pulse, then `ld_data` = 0 and `stall` low.
- **Async reset in EXT_RWAIT:** assert `reset_n` low. Expect `ext_read` = 0 and `stall` = 0 immediately; the next local load returns correct data.
